// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, arbiter state encoding and {x,y} address packing
// for the 640x480 1-bit frame buffer.
package fb_pkg;

  localparam int FB_ADDR_W = 19;
  localparam int FB_X_W    = 10;
  localparam int FB_Y_W    = 9;
  localparam int FB_X_MAX  = 640;
  localparam int FB_Y_MAX  = 480;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

  function automatic logic [FB_ADDR_W-1:0] fb_pack_addr(
    input logic [FB_X_W-1:0] x,
    input logic [FB_Y_W-1:0] y
  );
    return {x, y};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first request at or above ptr_i,
// wrapping at N-1. Purely combinational.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o
);

  typedef logic [N-1:0] vec_t;

  localparam vec_t ONE = vec_t'(1);

  vec_t req_rot;
  vec_t gnt_rot;

  // Rotate so the pointer position lands on bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into place.
  assign req_rot = vec_t'({req_i, req_i} >> ptr_i);
  assign gnt_rot = req_rot & ((~req_rot) + ONE);
  assign gnt_o   = en_i ? vec_t'({gnt_rot, gnt_rot} >> (N - int'(ptr_i))) : '0;

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin sharing of frame-buffer port A between N_REQ engines, with tagged
// fixed-latency read return and a built-in full-screen clear sweep.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int X_MAX  = FB_X_MAX,
  parameter int Y_MAX  = FB_Y_MAX
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [N_REQ-1:0]        iREQ,
  input  logic [N_REQ-1:0]        iWR,
  input  logic [N_REQ*ADDR_W-1:0] iADDR,
  input  logic [N_REQ-1:0]        iWDATA,
  output logic [N_REQ-1:0]        oGNT,
  input  logic                    iHOLD,
  input  logic                    iCLEAR,
  output logic                    oCLEAR_BUSY,
  output logic [ADDR_W-1:0]       oMEM_ADDR,
  output logic                    oMEM_DATA,
  output logic                    oMEM_WE,
  input  logic                    iMEM_Q,
  output logic [N_REQ-1:0]        oRVALID,
  output logic                    oRDATA
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [FB_X_W-1:0] x_t;
  typedef logic [FB_Y_W-1:0] y_t;
  typedef logic [N_REQ-1:0]  req_t;

  fb_state_e state_q, state_d;
  ptr_t      ptr_q, ptr_d;
  x_t        x_q, x_d;
  y_t        y_q, y_d;
  addr_t     mem_addr_q, mem_addr_d;
  logic      mem_data_q, mem_data_d;
  logic      mem_we_q, mem_we_d;
  req_t      tag1_q, tag1_d;
  req_t      tag2_q;
  req_t      rvalid_q;
  logic      rdata_q;

  req_t  gnt;
  logic  arb_en;
  logic  xfer;
  ptr_t  gnt_idx;
  addr_t sel_addr;
  logic  sel_wr;
  logic  sel_wd;

  // A pending clear wins over requests on the very cycle it is sampled.
  assign arb_en = (state_q == ST_ARB) && !iHOLD && !iCLEAR;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req_i (iREQ),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign xfer = |gnt;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_wd   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = ptr_t'(i);
        sel_addr = iADDR[i*ADDR_W +: ADDR_W];
        sel_wr   = iWR[i];
        sel_wd   = iWDATA[i];
      end
    end
  end

  assign ptr_d = !xfer                          ? ptr_q :
                 (gnt_idx == ptr_t'(N_REQ - 1)) ? '0    :
                                                  gnt_idx + ptr_t'(1);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    tag1_d     = '0;
    unique case (state_q)
      ST_ARB: begin
        if (iCLEAR) begin
          state_d = ST_CLEAR;
          x_d     = '0;
          y_d     = '0;
        end else if (xfer) begin
          mem_addr_d = sel_addr;
          mem_data_d = sel_wd;
          mem_we_d   = sel_wr;
          tag1_d     = sel_wr ? '0 : gnt;
        end
      end
      ST_CLEAR: begin
        mem_addr_d = addr_t'(fb_pack_addr(x_q, y_q));
        mem_data_d = 1'b0;
        mem_we_d   = 1'b1;
        // y sweeps fastest; the last column's last row ends the sweep.
        if (y_q == y_t'(Y_MAX - 1)) begin
          y_d = '0;
          if (x_q == x_t'(X_MAX - 1)) begin
            x_d     = '0;
            state_d = ST_DONE;
          end else begin
            x_d = x_q + x_t'(1);
          end
        end else begin
          y_d = y_q + y_t'(1);
        end
      end
      ST_DONE: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mem_addr_q <= '0;
      mem_data_q <= 1'b0;
      mem_we_q   <= 1'b0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      rvalid_q   <= '0;
      rdata_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag1_q;
      rvalid_q   <= tag2_q;
      rdata_q    <= iMEM_Q;
    end
  end

  assign oGNT        = gnt;
  assign oCLEAR_BUSY = (state_q == ST_CLEAR);
  assign oMEM_ADDR   = mem_addr_q;
  assign oMEM_DATA   = mem_data_q;
  assign oMEM_WE     = mem_we_q;
  assign oRVALID     = rvalid_q;
  assign oRDATA      = rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: a behavioural model predicts grants, memory
// writes and tagged read returns; a negedge monitor pops and compares them.
module tb_fb_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 19;
  localparam int XM = 4;
  localparam int YM = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AW-1:0] addr_bus;
  logic [N-1:0]    wdata;
  logic [N-1:0]    gnt;
  logic            hold;
  logic            clear;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_data;
  logic            mem_we;
  logic            mem_q = 1'b0;
  logic [N-1:0]    rvalid;
  logic            rdata;

  fb_port_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .X_MAX  (XM),
    .Y_MAX  (YM)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iREQ        (req),
    .iWR         (wr),
    .iADDR       (addr_bus),
    .iWDATA      (wdata),
    .oGNT        (gnt),
    .iHOLD       (hold),
    .iCLEAR      (clear),
    .oCLEAR_BUSY (busy),
    .oMEM_ADDR   (mem_addr),
    .oMEM_DATA   (mem_data),
    .oMEM_WE     (mem_we),
    .iMEM_Q      (mem_q),
    .oRVALID     (rvalid),
    .oRDATA      (rdata)
  );

  always #5 clk = ~clk;

  // Frame buffer port A: registered read, new data on read-during-write.
  bit fb_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) fb_mem[mem_addr] <= mem_data;
    mem_q <= mem_we ? mem_data : fb_mem[mem_addr];
  end

  typedef struct {int cyc; int addr; bit data;} wr_exp_t;
  typedef struct {int cyc; int idx;  bit data;} rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];
  wr_exp_t mon_w;
  rd_exp_t mon_r;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: screen contents, rotation pointer, clear progress.
  bit m_mem[int];
  int m_ptr   = 0;
  int m_sweep = -1;
  bit m_done  = 1'b0;

  bit [N-1:0] a_req;
  bit         a_wr   [N];
  int         a_addr [N];
  bit         a_wd   [N];
  int         pool   [8];

  function automatic int pk(input int x, input int y);
    return x * 512 + y;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]              = a_req[i];
      wr[i]               = a_wr[i];
      wdata[i]            = a_wd[i];
      addr_bus[i*AW +: AW] = AW'(a_addr[i]);
    end
  endtask

  task automatic new_req(input int i);
    a_req[i]  = 1'b1;
    a_wr[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = pool[$urandom_range(0, 7)];
    a_wd[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic set_req(input int i, input bit w, input int a, input bit d);
    a_req[i]  = 1'b1;
    a_wr[i]   = w;
    a_addr[i] = a;
    a_wd[i]   = d;
  endtask

  // One clock of the reference model, evaluated on the pre-edge inputs.
  task automatic model_cycle();
    bit [N-1:0] exp_g;
    bit         exp_busy;
    int         g;
    rd_exp_t    r;
    wr_exp_t    w;
    exp_g    = '0;
    exp_busy = (m_sweep >= 0);
    if (m_sweep >= 0) begin
      w.cyc = cyc + 1; w.addr = pk(m_sweep / YM, m_sweep % YM); w.data = 1'b0;
      wq.push_back(w);
      m_sweep++;
      if (m_sweep == XM * YM) begin
        m_sweep = -1;
        m_done  = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (clear) begin
      m_sweep = 0;
      for (int s = 0; s < XM * YM; s++) m_mem[pk(s / YM, s % YM)] = 1'b0;
    end else if (!hold && req != '0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_g[g] = 1'b1;
      if (wr[g]) begin
        m_mem[a_addr[g]] = wdata[g];
        w.cyc = cyc + 1; w.addr = a_addr[g]; w.data = wdata[g];
        wq.push_back(w);
      end else begin
        r.cyc  = cyc + 3;
        r.idx  = g;
        r.data = m_mem.exists(a_addr[g]) ? m_mem[a_addr[g]] : 1'b0;
        rq.push_back(r);
      end
      m_ptr = (g + 1) % N;
    end
    check("grant", longint'(gnt), longint'(exp_g));
    check("clear_busy", longint'(busy), longint'(exp_busy));
  endtask

  // mode 0: drop a request once granted; 1: keep requesting; 2: random traffic.
  task automatic step(input int mode);
    bit [N-1:0] g_seen;
    drive();
    @(negedge clk);
    model_cycle();
    g_seen = gnt;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (mode == 0 && g_seen[i]) a_req[i] = 1'b0;
      if (mode == 2) begin
        if (a_req[i] && g_seen[i]) begin
          if ($urandom_range(0, 3) == 0) a_req[i] = 1'b0;
          else new_req(i);
        end else if (!a_req[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
    end
    if (mode == 2) begin
      hold  = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 63) == 0);
    end
  endtask

  task automatic do_reset(input int n_cycles);
    rst_n = 1'b0;
    a_req = '0;
    hold  = 1'b0;
    clear = 1'b0;
    drive();
    wq.delete();
    rq.delete();
    m_ptr   = 0;
    m_sweep = -1;
    m_done  = 1'b0;
    #1;
    check("rst_mem_addr", longint'(mem_addr), 0);
    check("rst_mem_data", longint'(mem_data), 0);
    check("rst_mem_we",   longint'(mem_we),   0);
    check("rst_rvalid",   longint'(rvalid),   0);
    check("rst_rdata",    longint'(rdata),    0);
    check("rst_busy",     longint'(busy),     0);
    repeat (n_cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mem_write: unexpected write addr %0h data %0b (cycle %0d)", mem_addr, mem_data, cyc);
        end else begin
          mon_w = wq.pop_front();
          check("mem_write", longint'({cyc, mem_addr, mem_data}),
                longint'({mon_w.cyc, AW'(mon_w.addr), mon_w.data}));
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        mon_w = wq.pop_front();
        n_checks++; n_errors++;
        $display("FAIL mem_write: missing write addr %0h expected at cycle %0d, got none", mon_w.addr, mon_w.cyc);
      end
      if (rvalid != '0) begin
        if (rq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL read_return: unexpected strobe %b (cycle %0d)", rvalid, cyc);
        end else begin
          mon_r = rq.pop_front();
          check("read_return", longint'({cyc, rvalid, rdata}),
                longint'({mon_r.cyc, N'(1) << mon_r.idx, mon_r.data}));
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        mon_r = rq.pop_front();
        n_checks++; n_errors++;
        $display("FAIL read_return: missing return to %0d expected at cycle %0d, got none", mon_r.idx, mon_r.cyc);
      end
    end
  end

  initial begin
    pool[0] = pk(0, 0);   pool[1] = pk(0, 1);
    pool[2] = pk(1, 2);   pool[3] = pk(3, 2);
    pool[4] = pk(160, 240); pool[5] = pk(639, 479);
    pool[6] = pk(2, 0);   pool[7] = pk(4, 0);
    for (int i = 0; i < N; i++) begin
      a_wr[i] = 1'b0; a_addr[i] = 0; a_wd[i] = 1'b0;
    end
    a_req = '0;
    hold  = 1'b0;
    clear = 1'b0;
    rst_n = 1'b1;
    drive();
    #3;
    do_reset(2);

    // Write then read-after-write of {160,240}.
    set_req(1, 1'b1, pk(160, 240), 1'b1);
    step(0);
    set_req(0, 1'b0, pk(160, 240), 1'b0);
    repeat (4) step(0);

    // Bring the pointer to 0, then all four requesting continuously.
    set_req(3, 1'b0, pk(0, 0), 1'b0);
    step(0);
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), pool[i], 1'b1);
    repeat (8) step(1);
    a_req = '0;
    repeat (3) step(0);

    // Hold blocks grants; release grants requester 2.
    set_req(2, 1'b0, pk(160, 240), 1'b0);
    hold = 1'b1;
    repeat (3) step(0);
    hold = 1'b0;
    repeat (4) step(0);

    // Clear pulse while requester 0 waits.
    set_req(0, 1'b1, pk(4, 0), 1'b1);
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    repeat (18) step(0);

    // Reset in the cycle after a read transfer.
    set_req(0, 1'b0, pk(4, 0), 1'b0);
    step(0);
    do_reset(2);
    a_req = '1;
    repeat (4) step(1);
    a_req = '0;
    repeat (2) step(0);

    // Reset mid-sweep, then a full clean sweep.
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    repeat (5) step(0);
    do_reset(2);
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    repeat (16) step(0);

    repeat (3000) step(2);

    a_req = '0;
    hold  = 1'b0;
    clear = 1'b0;
    for (int t = 0; t < 20 && (wq.size() + rq.size() + m_sweep + 1) != 0; t++) step(0);
    repeat (3) step(0);
    check("queues_drained", longint'(wq.size() + rq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares port A of the 1-bit 640x480 frame buffer (address = {x[9:0], y[8:0]}) between N sequencing engines, for example several DLA walkers or a seeder. It uses round-robin arbitration with a valid/ready request handshake. Read data returns with a fixed latency, tagged per requester. A built-in clear engine takes exclusive ownership of the port and zeroes the whole screen. The VGA refresh keeps sole use of port B and is untouched.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 19, frame buffer address width, {x,y}
X_MAX, 640, clear sweep column count
Y_MAX, 480, clear sweep row count

Ports:
iCLK  in  1  system clock (VGA_CTRL_CLK domain)
iRST_N  in  1  asynchronous active-low reset
iREQ  in  N_REQ  per-requester request valid
iWR  in  N_REQ  per-requester: 1 = write, 0 = read
iADDR  in  N_REQ*ADDR_W  per-requester address, slice i = bits [i*ADDR_W +: ADDR_W]
iWDATA  in  N_REQ  per-requester write bit
oGNT  out  N_REQ  one-hot ready, combinational
iHOLD  in  1  pause: no grants while high
iCLEAR  in  1  start full-screen clear (level-sampled)
oCLEAR_BUSY  out  1  clear sweep in progress
oMEM_ADDR  out  ADDR_W  to buffer address_a, registered
oMEM_DATA  out  1  to buffer data_a, registered
oMEM_WE  out  1  to buffer wren_a, registered
iMEM_Q  in  1  from buffer q_a
oRVALID  out  N_REQ  one-hot read-return strobe, registered
oRDATA  out  1  read-return bit, registered

Behaviour:
- Reset values, all asynchronous: oMEM_ADDR=0, oMEM_DATA=0, oMEM_WE=0, oRVALID=0, oRDATA=0, oCLEAR_BUSY=0, round-robin pointer=0, state=ARB.
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep in progress.
  - DONE: one cycle; drives WE=0, then returns to ARB.
- Grant rule:
  - In ARB with iHOLD=0, oGNT is one-hot: the first set iREQ bit searching upward from the pointer, wrapping at N_REQ-1.
  - oGNT is all-zero in CLEAR, in DONE, when iHOLD=1, or when iREQ=0.
- Transfer handshake:
  - A transfer occurs at a rising edge where iREQ[i] & oGNT[i].
  - The requester holds iWR, iADDR and iWDATA stable while iREQ is high and unaccepted.
  - iREQ may stay high for back-to-back transfers.
- Pointer update: on a transfer to i, the pointer becomes i+1, wrapping to 0 after N_REQ-1.
- Memory drive on a transfer edge E:
  - oMEM_ADDR, oMEM_DATA and oMEM_WE (=iWR[i]) all update together at E.
  - With no transfer, oMEM_WE=0 and addr/data hold their values.
- Read return:
  - The buffer samples the address at E+1; iMEM_Q is valid after E+1.
  - At E+2, oRVALID[i]=1 for one cycle and oRDATA=iMEM_Q.
  - The requester index travels in a 2-deep tag pipeline.
  - Back-to-back reads return back-to-back.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. The buffer's port-A read-during-write setting is configured to guarantee this.
- Clear entry:
  - iCLEAR=1 sampled in ARB moves the block to CLEAR.
  - oGNT is forced to 0 on that same cycle, so CLEAR has priority over requests.
- Clear sweep:
  - oMEM_WE=1, oMEM_DATA=0 every cycle.
  - Addresses run {x,y} with y inner 0..Y_MAX-1 and x outer 0..X_MAX-1, one per cycle, X_MAX*Y_MAX cycles total.
  - Counters are 10-bit x and 9-bit y; each wraps to 0 at its max.
  - oCLEAR_BUSY is high through every CLEAR cycle.
  - After the last write, the block goes to DONE, then to ARB.
- During CLEAR, iCLEAR and iHOLD are ignored. Reads already in the tag pipeline still return normally.
- iHOLD does not stop the tag pipeline or a sweep in progress.
- Reset mid-sweep or mid-read aborts immediately; pending oRVALID strobes are dropped.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=19, FB_X_W=10, FB_Y_W=9, FB_X_MAX=640, FB_Y_MAX=480;
  - the state encoding ARB/CLEAR/DONE;
  - a helper that packs {x,y} into a frame buffer address.
- One sub-module, rr_arbiter: parameterised N-way round-robin. Inputs are the request vector, the pointer and an enable; output is the one-hot grant (combinational).
- The tag pipeline and the clear counters stay in fb_port_arbiter.

Test Plan:
1. Reset, then requester 1 writes 1 to {160,240}: transfer at edge E; at E, oMEM_ADDR={10'd160,9'd240}, oMEM_DATA=1, oMEM_WE=1. The next cycle, oMEM_WE=0.
2. Requester 0 reads {160,240} the cycle after test 1's write: oRVALID=4'b0001 and oRDATA=1 two edges after the transfer. Every other oRVALID bit stays 0.
3. iREQ=4'b1111 held for 8 cycles from pointer 0: grants in order 0,1,2,3,0,1,2,3, one per cycle, no gaps.
4. iHOLD=1 with iREQ=4'b0100: oGNT=0 and oMEM_WE=0 throughout. Release iHOLD: grant 2 on the next edge.
5. With X_MAX=4, Y_MAX=3 and iCLEAR pulsed while iREQ=4'b0001:
   - 12 consecutive WE=1, DATA=0 cycles at addresses {0,0},{0,1},{0,2},{1,0} .. {3,2};
   - oCLEAR_BUSY high for exactly 12 cycles, no grants;
   - requester 0 granted 2 cycles after BUSY falls.
6. Deassert iRST_N mid-sweep and in the cycle after a read transfer: all outputs go to 0 at once. After release: no stray oRVALID, state ARB, pointer 0.
